// File: rtl/video_line_scaler.sv
// Captures native pixel lines into a ring of line buffers and replays them at the generator's beam
// position with integer scaling/offsets; read path is 2 cycles from i_x/i_y/i_de to o_r/o_g/o_b.
module video_line_scaler #(
    parameter int SRC_MAX_PIX = 1024,
    parameter int NUM_LINES   = 4,
    parameter int HZ_SHIFT    = 1,
    parameter int VT_SHIFT    = 1,
    parameter int X_OFFSET    = 0,
    parameter int Y_OFFSET    = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_pix_en,
    input  logic [7:0]                   i_r,
    input  logic [7:0]                   i_g,
    input  logic [7:0]                   i_b,
    input  logic                         i_hsync,
    input  logic                         i_vsync,
    input  logic [11:0]                  i_x,
    input  logic [11:0]                  i_y,
    input  logic                         i_de,
    output logic [7:0]                   o_r,
    output logic [7:0]                   o_g,
    output logic [7:0]                   o_b,
    output logic                         o_frame_end,
    output logic [$clog2(NUM_LINES)-1:0] o_wr_line,
    output logic                         o_underrun
);
    localparam int CW = $clog2(SRC_MAX_PIX);
    localparam int LW = $clog2(NUM_LINES);
    localparam int AW = CW + LW;

    logic [23:0]   ram [NUM_LINES*SRC_MAX_PIX];

    // ---------------- write side ----------------
    // wr_col carries one extra bit so the "line full" state is representable without wrapping.
    logic [CW:0]   wr_col;
    logic [LW-1:0] wr_ptr;
    logic          hs_prev;
    logic          vs_prev;
    logic          hs_edge;
    logic          vs_edge;
    logic          wr_en;

    assign hs_edge = i_hsync & ~hs_prev;
    assign vs_edge = i_vsync & ~vs_prev;
    assign wr_en   = i_pix_en & ~wr_col[CW];

    always_ff @(posedge clk) begin
        if (wr_en)
            ram[{wr_ptr, wr_col[CW-1:0]}] <= {i_r, i_g, i_b};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_col      <= '0;
            wr_ptr      <= '0;
            hs_prev     <= 1'b0;
            vs_prev     <= 1'b0;
            o_frame_end <= 1'b0;
        end else begin
            hs_prev     <= i_hsync;
            vs_prev     <= i_vsync;
            o_frame_end <= vs_edge;
            if (vs_edge) begin
                wr_ptr <= '0;
                wr_col <= '0;
            end else if (hs_edge) begin
                wr_ptr <= wr_ptr + 1'b1;
                wr_col <= '0;
            end else if (wr_en) begin
                wr_col <= wr_col + 1'b1;
            end
        end
    end

    assign o_wr_line = wr_ptr;

    // ---------------- read side ----------------
    // Subtractions wrap on underflow; the >= compares reject those beam positions.
    logic [11:0]   dx;
    logic [11:0]   dy;
    logic [11:0]   col_full;
    logic [LW-1:0] rd_line;
    logic          rd_vld_s1;
    logic [AW-1:0] rd_addr_q;
    logic          rd_vld_q;
    logic          rd_vld_d;
    logic [23:0]   rd_data;

    assign dx        = i_x - 12'(X_OFFSET);
    assign dy        = i_y - 12'(Y_OFFSET);
    assign col_full  = dx >> HZ_SHIFT;
    assign rd_line   = LW'(dy >> VT_SHIFT);
    assign rd_vld_s1 = i_de && (i_x >= 12'(X_OFFSET)) && (i_y >= 12'(Y_OFFSET))
                       && ((col_full >> CW) == 12'd0);

    always_ff @(posedge clk) begin
        rd_addr_q <= {rd_line, CW'(col_full)};
        rd_data   <= ram[rd_addr_q];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vld_q   <= 1'b0;
            rd_vld_d   <= 1'b0;
            o_underrun <= 1'b0;
        end else begin
            rd_vld_q <= rd_vld_s1;
            rd_vld_d <= rd_vld_q;
            if (rd_vld_s1 && rd_line == wr_ptr)
                o_underrun <= 1'b1;
        end
    end

    assign o_r = rd_vld_d ? rd_data[23:16] : 8'd0;
    assign o_g = rd_vld_d ? rd_data[15:8]  : 8'd0;
    assign o_b = rd_vld_d ? rd_data[7:0]   : 8'd0;
endmodule

// File: tb/tb_video_line_scaler.sv
// Directed bench for video_line_scaler (Y_OFFSET=10, other parameters default).
module tb_video_line_scaler;
    logic        clk = 1'b0;
    logic        reset;
    logic        i_pix_en;
    logic [7:0]  i_r, i_g, i_b;
    logic        i_hsync, i_vsync;
    logic [11:0] i_x, i_y;
    logic        i_de;
    logic [7:0]  o_r, o_g, o_b;
    logic        o_frame_end;
    logic [1:0]  o_wr_line;
    logic        o_underrun;

    int total = 0;
    int bad   = 0;

    logic [23:0] line0 [4] = '{24'h112233, 24'h223344, 24'h334455, 24'h445566};

    video_line_scaler #(.Y_OFFSET(10)) dut (
        .clk(clk), .reset(reset), .i_pix_en(i_pix_en),
        .i_r(i_r), .i_g(i_g), .i_b(i_b),
        .i_hsync(i_hsync), .i_vsync(i_vsync),
        .i_x(i_x), .i_y(i_y), .i_de(i_de),
        .o_r(o_r), .o_g(o_g), .o_b(o_b),
        .o_frame_end(o_frame_end), .o_wr_line(o_wr_line), .o_underrun(o_underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic [23:0] rgb);
        i_pix_en = 1'b1;
        {i_r, i_g, i_b} = rgb;
        tick();
        i_pix_en = 1'b0;
    endtask

    task automatic hsync_pulse();
        i_hsync = 1'b1;
        tick();
        i_hsync = 1'b0;
        tick();
    endtask

    // Present one beam position for one cycle; the pixel appears two edges later.
    task automatic rd(input string tag, input int x, input int y, input logic de,
                      input logic [23:0] exp);
        i_x  = 12'(x);
        i_y  = 12'(y);
        i_de = de;
        tick();
        i_de = 1'b0;
        tick();
        chk(tag, {8'd0, o_r, o_g, o_b}, {8'd0, exp});
    endtask

    initial begin
        reset = 1'b1; i_pix_en = 1'b0; {i_r, i_g, i_b} = '0;
        i_hsync = 1'b0; i_vsync = 1'b0; i_x = '0; i_y = '0; i_de = 1'b0;
        tick(); tick();
        chk("rst_rgb", {8'd0, o_r, o_g, o_b}, 32'd0);
        chk("rst_fe", 32'(o_frame_end), 32'd0);
        chk("rst_wrline", 32'(o_wr_line), 32'd0);
        chk("rst_underrun", 32'(o_underrun), 32'd0);
        reset = 1'b0;
        tick();

        // Line 0 capture and 2x horizontal replay
        for (int k = 0; k < 4; k++) pix(line0[k]);
        hsync_pulse();
        chk("wrline_after_hs", 32'(o_wr_line), 32'd1);
        for (int x = 0; x < 8; x++) rd($sformatf("l0_x%0d", x), x, 10, 1'b1, line0[x >> 1]);

        // Vertical offset and line doubling
        rd("y_below_off", 0, 9, 1'b1, 24'h0);
        rd("y10", 0, 10, 1'b1, 24'h112233);
        rd("y11", 2, 11, 1'b1, 24'h223344);
        rd("de_low", 0, 10, 1'b0, 24'h0);

        // Overlong line into slot 1: columns past 1023 dropped, no wrap
        i_pix_en = 1'b1;
        for (int k = 0; k < 1030; k++) begin
            {i_r, i_g, i_b} = 24'hA00000 | 24'(k);
            tick();
        end
        i_pix_en = 1'b0;
        hsync_pulse();
        rd("col1023", 2046, 12, 1'b1, 24'hA003FF);
        rd("col0_nowrap", 0, 12, 1'b1, 24'hA00000);
        rd("col1", 2, 12, 1'b1, 24'hA00001);
        rd("col1024_oob", 2048, 12, 1'b1, 24'h0);

        // vsync frame_end and pointer reset
        hsync_pulse();
        chk("wrline3", 32'(o_wr_line), 32'd3);
        i_vsync = 1'b1;
        chk("fe_before", 32'(o_frame_end), 32'd0);
        tick();
        chk("fe_pulse", 32'(o_frame_end), 32'd1);
        chk("wrline_vs", 32'(o_wr_line), 32'd0);
        tick();
        chk("fe_one_cycle", 32'(o_frame_end), 32'd0);
        i_vsync = 1'b0;
        tick();
        hsync_pulse();
        chk("wrline1_again", 32'(o_wr_line), 32'd1);
        i_hsync = 1'b1; i_vsync = 1'b1;
        tick();
        chk("fe_hs_vs", 32'(o_frame_end), 32'd1);
        chk("wrline_hs_vs", 32'(o_wr_line), 32'd0);
        i_hsync = 1'b0; i_vsync = 1'b0;
        tick();
        chk("wrline_hs_vs_hold", 32'(o_wr_line), 32'd0);
        chk("no_underrun_yet", 32'(o_underrun), 32'd0);

        // Underrun: read the slot currently being written
        rd("underrun_read", 0, 10, 1'b1, 24'h112233);
        chk("underrun_set", 32'(o_underrun), 32'd1);
        i_vsync = 1'b1; tick(); i_vsync = 1'b0; tick();
        hsync_pulse();
        chk("underrun_sticky", 32'(o_underrun), 32'd1);

        // Mid-line reset with active read and coincident vsync
        hsync_pulse();
        pix(24'h777777);
        i_x = 12'd0; i_y = 12'd10; i_de = 1'b1;
        tick();
        reset = 1'b1; i_vsync = 1'b1;
        tick();
        chk("mid_rst_rgb", {8'd0, o_r, o_g, o_b}, 32'd0);
        chk("mid_rst_wrline", 32'(o_wr_line), 32'd0);
        chk("mid_rst_underrun", 32'(o_underrun), 32'd0);
        chk("mid_rst_fe", 32'(o_frame_end), 32'd0);
        reset = 1'b0; i_vsync = 1'b0; i_de = 1'b0;
        tick();
        chk("post_rst_fe", 32'(o_frame_end), 32'd0);
        pix(24'hABCDEF);
        hsync_pulse();
        rd("post_rst_slot0_col0", 0, 10, 1'b1, 24'hABCDEF);
        rd("post_rst_col1_kept", 2, 10, 1'b1, 24'h223344);
        chk("post_rst_underrun", 32'(o_underrun), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
